cpu_muldiv: RTL and testbench

- Iterative multiply/divide unit implementing the RV32M operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU).
- Sits beside cpu_alu in the execute stage. The core stalls on `in_ready`/`out_valid` while a long op is in flight.
- Unlike the single-cycle ALU it is sequential and operand-width parametrised: a radix-2 shift-add/shift-subtract datapath with a valid/ready handshake on both sides, a flush input, and ALU-compatible zero/neg flags.

---
 rtl/cpu_muldiv_pkg.sv | 47 ++++
 rtl/cpu_muldiv_if.sv | 28 ++
 rtl/cpu_muldiv_step.sv | 34 +++
 rtl/cpu_muldiv.sv | 133 +++++++++++++
 tb/tb_cpu_muldiv.sv | 328 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_muldiv_pkg.sv
// Shared types for the iterative RV32M multiply/divide unit: funct3 op codes,
// FSM states, step modes and operand-sign helpers.
package cpu_muldiv_pkg;

  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } md_op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_BUSY,
    S_FIX,
    S_DONE
  } state_e;

  typedef enum logic {
    STEP_MUL,
    STEP_DIV
  } step_mode_e;

  function automatic logic is_div(md_op_e op);
    return op inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU};
  endfunction

  function automatic logic is_rem(md_op_e op);
    return op inside {MD_REM, MD_REMU};
  endfunction

  // src_a is signed for MULH, MULHSU, DIV and REM
  function automatic logic a_signed(md_op_e op);
    return op inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
  endfunction

  // src_b is signed for MULH, DIV and REM only
  function automatic logic b_signed(md_op_e op);
    return op inside {MD_MULH, MD_DIV, MD_REM};
  endfunction

endpackage

// File: rtl/cpu_muldiv_if.sv
// Request/response bundle between the execute stage (master) and the
// multiply/divide unit (slave).
interface cpu_muldiv_if
  import cpu_muldiv_pkg::*;
#(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  md_op_e          op;
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero;
  logic            neg;

  modport master (
    output in_valid, op, src_a, src_b, out_ready,
    input  in_ready, out_valid, result, zero, neg
  );

  modport slave (
    input  in_valid, op, src_a, src_b, out_ready,
    output in_ready, out_valid, result, zero, neg
  );
endinterface

// File: rtl/cpu_muldiv_step.sv
// One radix-2 iteration: shift-add for multiply, restoring shift-subtract for
// divide. acc is {high, low}; the quotient bit is returned separately.
module cpu_muldiv_step
  import cpu_muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  step_mode_e        mode,
  input  logic [2*XLEN-1:0] acc,
  input  logic [XLEN-1:0]   operand,
  output logic [2*XLEN-1:0] acc_next,
  output logic              q_bit
);
  logic [XLEN:0] sum;
  logic [XLEN:0] diff;

  always_comb begin
    acc_next = '0;
    q_bit    = 1'b0;
    sum      = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, operand} : '0);
    // partial remainder after the left shift needs XLEN+1 bits
    diff     = acc[2*XLEN-1:XLEN-1] - {1'b0, operand};
    if (mode == STEP_MUL) begin
      acc_next = {sum, acc[XLEN-1:1]};
    end else begin
      q_bit = ~diff[XLEN];
      if (q_bit) begin
        acc_next = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b0};
      end else begin
        acc_next = {acc[2*XLEN-2:0], 1'b0};
      end
    end
  end
endmodule

// File: rtl/cpu_muldiv.sv
// Sequential RV32M multiply/divide unit: PREP takes operand magnitudes, BUSY
// runs XLEN radix-2 steps, FIX restores signs and selects the result half.
module cpu_muldiv
  import cpu_muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input logic         clk,
  input logic         rst_n,
  input logic         flush,
  cpu_muldiv_if.slave bus
);
  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_e            state, state_next;
  md_op_e            op_q;
  logic [XLEN-1:0]   a_q, b_q, opnd, result_q;
  logic [2*XLEN-1:0] acc, acc_step;
  logic [CNT_W-1:0]  cnt;
  logic              neg_res, bypass, q_bit;

  logic              sign_a, sign_b, div_op, rem_op;
  logic              div_zero, ovf, special;
  logic [XLEN-1:0]   mag_a, mag_b, special_val;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   div_sel, div_fix, fix_val;
  step_mode_e        step_mode;

  always_comb begin
    div_op      = is_div(op_q);
    rem_op      = is_rem(op_q);
    sign_a      = a_signed(op_q) & a_q[XLEN-1];
    sign_b      = b_signed(op_q) & b_q[XLEN-1];
    mag_a       = sign_a ? -a_q : a_q;
    mag_b       = sign_b ? -b_q : b_q;
    div_zero    = div_op && (b_q == '0);
    ovf         = (op_q inside {MD_DIV, MD_REM}) && (a_q == MIN_NEG) && (b_q == '1);
    special     = div_zero | ovf;
    special_val = div_zero ? (rem_op ? a_q : '1) : (rem_op ? '0 : a_q);
    step_mode   = div_op ? STEP_DIV : STEP_MUL;
  end

  always_comb begin
    prod    = neg_res ? -acc : acc;
    div_sel = rem_op ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0];
    div_fix = neg_res ? -div_sel : div_sel;
    fix_val = div_fix;
    case (op_q)
      MD_MUL:                       fix_val = prod[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: fix_val = prod[2*XLEN-1:XLEN];
      default:                      fix_val = div_fix;
    endcase
  end

  cpu_muldiv_step #(.XLEN(XLEN)) u_step (
    .mode     (step_mode),
    .acc      (acc),
    .operand  (opnd),
    .acc_next (acc_step),
    .q_bit    (q_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Special cases load result in PREP and pass through FIX untouched, so every
  // path reaches DONE via the same FIX stage.
  always_comb begin
    state_next   = state;
    bus.in_ready = (state == S_IDLE);
    bus.out_valid = (state == S_DONE);
    case (state)
      S_IDLE:  if (bus.in_valid) state_next = S_PREP;
      S_PREP:  state_next = special ? S_FIX : S_BUSY;
      S_BUSY:  if (cnt == CNT_W'(XLEN - 1)) state_next = S_FIX;
      S_FIX:   state_next = S_DONE;
      S_DONE:  if (bus.out_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    if (flush) state_next = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= MD_MUL;
      a_q      <= '0;
      b_q      <= '0;
      opnd     <= '0;
      acc      <= '0;
      cnt      <= '0;
      neg_res  <= 1'b0;
      bypass   <= 1'b0;
      result_q <= '0;
    end else if (!flush) begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            op_q <= bus.op;
            a_q  <= bus.src_a;
            b_q  <= bus.src_b;
          end
        end
        S_PREP: begin
          cnt     <= '0;
          bypass  <= special;
          neg_res <= rem_op ? sign_a : (sign_a ^ sign_b);
          acc     <= div_op ? {{XLEN{1'b0}}, mag_a} : {{XLEN{1'b0}}, mag_b};
          opnd    <= div_op ? mag_b : mag_a;
          if (special) result_q <= special_val;
        end
        S_BUSY: begin
          acc <= {acc_step[2*XLEN-1:1], acc_step[0] | q_bit};
          cnt <= cnt + 1'b1;
        end
        S_FIX: begin
          if (!bypass) result_q <= fix_val;
        end
        default: ;
      endcase
    end
  end

  assign bus.result = result_q;
  assign bus.zero   = (result_q == '0);
  assign bus.neg    = result_q[XLEN-1];

endmodule

// File: tb/tb_cpu_muldiv.sv
// Randomised scoreboard bench for cpu_muldiv against an arithmetic RV32M model,
// plus directed latency, backpressure, flush, reset and XLEN=16 cases.
module tb_cpu_muldiv;
  import cpu_muldiv_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  logic flush16;
  logic ready_cmd;
  logic rand_bp;
  logic rnd_ready;

  int n_cmp = 0;
  int n_fail = 0;
  logic [31:0] sb[$];

  cpu_muldiv_if #(.XLEN(32)) bus ();
  cpu_muldiv_if #(.XLEN(16)) bus16 ();

  cpu_muldiv #(.XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  cpu_muldiv #(.XLEN(16)) dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush16),
    .bus   (bus16)
  );

  always #5 clk = ~clk;

  assign bus.out_ready = rand_bp ? rnd_ready : ready_cmd;

  initial begin
    rnd_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      rnd_ready = ($urandom_range(0, 3) != 0);
    end
  end

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  // Reference model: plain 64-bit arithmetic on the RV32M definitions.
  function automatic logic [31:0] model(md_op_e o, logic [31:0] a, logic [31:0] b);
    longint          sa, sb2;
    longint unsigned ua, ub;
    logic [63:0]     p;
    int              ia, ib;
    sa  = longint'(int'(a));
    sb2 = longint'(int'(b));
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    ia  = int'(a);
    ib  = int'(b);
    case (o)
      MD_MUL:    begin p = ua * ub;             return p[31:0];  end
      MD_MULH:   begin p = sa * sb2;            return p[63:32]; end
      MD_MULHSU: begin p = sa * longint'(ub);   return p[63:32]; end
      MD_MULHU:  begin p = ua * ub;             return p[63:32]; end
      MD_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return 32'(ia / ib);
      end
      MD_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      MD_REM: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'(ia % ib);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_latency(md_op_e o, logic [31:0] a, logic [31:0] b);
    logic dz, ov;
    dz = (o inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU}) && (b == 0);
    ov = (o inside {MD_DIV, MD_REM}) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    return (dz || ov) ? 2 : 34;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Monitor: pops the scoreboard on every accepted result and checks that a
  // held result stays put while out_ready is low.
  logic        hold_prev = 1'b0;
  logic [31:0] prev_res = '0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.out_valid && hold_prev) check("hold_stable", bus.result, prev_res);
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_output", 32'd1, 32'd0);
        end else begin
          logic [31:0] e;
          e = sb.pop_front();
          check("result", bus.result, e);
          check("zero", {31'd0, bus.zero}, {31'd0, e == 0});
          check("neg", {31'd0, bus.neg}, {31'd0, e[31]});
        end
      end
      hold_prev = bus.out_valid && !bus.out_ready;
      prev_res  = bus.result;
    end else begin
      hold_prev = 1'b0;
    end
  end

  task automatic start_op(input md_op_e o, input logic [31:0] a, input logic [31:0] b,
                          output bit ok);
    int n;
    n = 0;
    while (!bus.in_ready && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!bus.in_ready) begin
      check("in_ready_wait", {31'd0, bus.in_ready}, 32'd1);
      ok = 1'b0;
      return;
    end
    bus.in_valid = 1'b1;
    bus.op       = o;
    bus.src_a    = a;
    bus.src_b    = b;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.op       = md_op_e'(3'($urandom_range(0, 7)));
    bus.src_a    = $urandom;
    bus.src_b    = $urandom;
    ok = 1'b1;
  endtask

  task automatic issue(input md_op_e o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int exp_lat);
    bit ok;
    int n;
    start_op(o, a, b, ok);
    if (!ok) return;
    sb.push_back(exp);
    check("in_ready_drop", {31'd0, bus.in_ready}, 32'd0);
    if (exp_lat > 0) begin
      n = 0;
      while (!bus.out_valid && n < 100) begin
        @(posedge clk);
        #1;
        n++;
      end
      check("latency", 32'(n), 32'(exp_lat));
    end
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
    check({tag, "_out_valid"}, {31'd0, bus.out_valid}, 32'd0);
    check({tag, "_result"}, bus.result, 32'd0);
    check({tag, "_zero"}, {31'd0, bus.zero}, 32'd1);
    check({tag, "_neg"}, {31'd0, bus.neg}, 32'd0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit     ok;
    int     n;
    bit     seen;
    md_op_e o;
    logic [31:0] a, b;

    rst_n = 1'b0;
    flush = 1'b0;
    flush16 = 1'b0;
    ready_cmd = 1'b0;
    rand_bp = 1'b0;
    bus.in_valid = 1'b0;
    bus.op = MD_MUL;
    bus.src_a = '0;
    bus.src_b = '0;
    bus16.in_valid = 1'b0;
    bus16.op = MD_MUL;
    bus16.src_a = '0;
    bus16.src_b = '0;
    bus16.out_ready = 1'b0;

    @(posedge clk);
    #1;
    check_reset_outputs("reset");
    check("reset16_result", {16'd0, bus16.result}, 32'd0);
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // MUL 7 x -3 with the result held under backpressure
    issue(MD_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);
    check("mul_neg_flag", {31'd0, bus.neg}, 32'd1);
    repeat (5) begin @(posedge clk); #1; end
    ready_cmd = 1'b1;

    issue(MD_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34);
    issue(MD_MULHSU, 32'h8000_0000, 32'h8000_0000, 32'hC000_0000, 34);
    issue(MD_MULHU,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34);
    issue(MD_DIV,    32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
    issue(MD_REM,    32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
    issue(MD_DIVU,   32'd100, 32'd7, 32'd14, 34);
    issue(MD_REMU,   32'd100, 32'd7, 32'd2, 34);
    issue(MD_DIV,    32'd5, 32'd0, 32'hFFFF_FFFF, 2);
    issue(MD_REMU,   32'd5, 32'd0, 32'd5, 2);
    issue(MD_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2);
    issue(MD_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 2);

    // flush mid-BUSY, with a competing request in the same cycle
    start_op(MD_MUL, 32'd9, 32'd9, ok);
    repeat (11) begin @(posedge clk); #1; end
    flush = 1'b1;
    bus.in_valid = 1'b1;
    bus.op = MD_DIVU;
    @(posedge clk);
    #1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    check("flush_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("flush_out_valid", {31'd0, bus.out_valid}, 32'd0);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen = 1'b1;
    end
    check("flush_no_output", {31'd0, seen}, 32'd0);
    issue(MD_MUL, 32'd3, 32'd4, 32'd12, 34);

    // randomised ops under random backpressure
    rand_bp = 1'b1;
    for (int i = 0; i < 150; i++) begin
      o = md_op_e'(3'($urandom_range(0, 7)));
      a = pick();
      b = pick();
      issue(o, a, b, model(o, a, b), exp_latency(o, a, b));
    end
    rand_bp = 1'b0;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain", 32'(sb.size()), 32'd0);
    repeat (2) begin @(posedge clk); #1; end

    // asynchronous reset in the middle of a divide
    start_op(MD_DIV, 32'd1000, 32'd7, ok);
    repeat (10) begin @(posedge clk); #1; end
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen = 1'b1;
    end
    check("rst_no_output", {31'd0, seen}, 32'd0);
    issue(MD_DIV, 32'd1000, 32'd7, 32'd142, 34);
    repeat (3) begin @(posedge clk); #1; end

    // XLEN=16 instance: MULHU 0xFFFF x 0xFFFF
    check("idle16", {31'd0, bus16.in_ready}, 32'd1);
    bus16.in_valid = 1'b1;
    bus16.op = MD_MULHU;
    bus16.src_a = 16'hFFFF;
    bus16.src_b = 16'hFFFF;
    @(posedge clk);
    #1;
    bus16.in_valid = 1'b0;
    bus16.src_a = 16'h1234;
    n = 0;
    while (!bus16.out_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("latency16", 32'(n), 32'd18);
    check("mulhu16", {16'd0, bus16.result}, 32'h0000_FFFE);
    check("neg16", {31'd0, bus16.neg}, 32'd1);
    bus16.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus16.out_ready = 1'b0;
    check("done16_idle", {31'd0, bus16.in_ready}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
